// File: rtl/score_digit_sequencer_if.sv
// Score/timing inputs and per-slot digit sprite outputs of score_digit_sequencer.
// The frame logic uses the master side; the sequencer uses the slave side.
interface score_digit_sequencer_if #(
  parameter int SCORE_W = 14
);
  logic [10:0]        hcount_in;
  logic               new_frame_in;
  logic [SCORE_W-1:0] score_in;
  logic [10:0]        x_out;
  logic [9:0]         y_out;
  logic [3:0]         number_out;
  logic               digit_en_out;
  logic               busy_out;
  logic               sat_out;

  modport master (
    output hcount_in, new_frame_in, score_in,
    input  x_out, y_out, number_out, digit_en_out, busy_out, sat_out
  );

  modport slave (
    input  hcount_in, new_frame_in, score_in,
    output x_out, y_out, number_out, digit_en_out, busy_out, sat_out
  );
endinterface

// File: rtl/score_digit_sequencer.sv
// Per-frame binary->BCD conversion (sequential double-dabble) and digit slot sequencing
// for a numbers-ROM sprite stage. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module score_digit_sequencer #(
  parameter int          SCORE_W    = 14,
  parameter int          NUM_DIGITS = 4,
  parameter int          WIDTH      = 24,
  parameter int          GAP        = 8,
  parameter logic [10:0] X0         = 11'd16,
  parameter logic [9:0]  Y0         = 10'd16
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  score_digit_sequencer_if.slave bus
);
  localparam int PITCH = WIDTH + GAP;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL  = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [10:0] SPAN_END = X0 + 11'(NUM_DIGITS * PITCH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

  state_t             state_reg, state_next;
  logic               busy;
  logic [CNT_W-1:0]   cnt_reg;
  logic [SCORE_W-1:0] bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic               sat_pend_reg;
  logic [BCD_W-1:0]   disp_reg;
  logic               sat_reg;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    unique case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.new_frame_in) state_next = S_LOAD;
      end
      S_LOAD:   state_next = S_SHIFT;
      S_SHIFT:  if (cnt_reg == CNT_W'(SCORE_W - 1)) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble before each shift
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dabble
      logic [3:0] nib;
      assign nib = bcd_reg[gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_reg      <= '0;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      sat_pend_reg <= 1'b0;
      disp_reg     <= '0;
      sat_reg      <= 1'b0;
    end else begin
      unique case (state_reg)
        S_LOAD: begin
          // Clamp keeps the BCD result within NUM_DIGITS digits
          if (64'(bus.score_in) > MAX_VAL) begin
            bin_reg      <= SCORE_W'(MAX_VAL);
            sat_pend_reg <= 1'b1;
          end else begin
            bin_reg      <= bus.score_in;
            sat_pend_reg <= 1'b0;
          end
          bcd_reg <= '0;
          cnt_reg <= '0;
        end
        S_SHIFT: begin
          {bcd_reg, bin_reg} <= {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
          cnt_reg            <= cnt_reg + CNT_W'(1);
        end
        S_COMMIT: begin
          disp_reg <= bcd_reg;
          sat_reg  <= sat_pend_reg;
        end
        default: ;
      endcase
    end
  end

  // ---------------- slot sequencing ----------------
  logic [3:0]            digit_w [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] slot_en;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_w[gi] = disp_reg[(NUM_DIGITS-1-gi)*4 +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    slot_en = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seen_nz    = seen_nz | (digit_w[k] != 4'd0);
      slot_en[k] = seen_nz | (k == NUM_DIGITS - 1);
    end
  end
`else
  assign slot_en = '1;
`endif

  logic [10:0]      h_next;
  logic             in_range;
  logic [SEL_W-1:0] sel;
  logic [10:0]      sel_x;

  always_comb begin
    h_next   = bus.hcount_in + 11'd1;
    in_range = (h_next >= X0) && (h_next < SPAN_END);
    sel      = '0;
    sel_x    = X0;
    if (in_range) begin
      for (int k = 1; k < NUM_DIGITS; k++) begin
        if (h_next >= X0 + 11'(k * PITCH)) begin
          sel   = SEL_W'(k);
          sel_x = X0 + 11'(k * PITCH);
        end
      end
    end
  end

  logic             in_range_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [10:0]      x_reg;
  logic [3:0]       number_reg;
  logic             en_reg;
  logic             slot_update;

  // Inside a slot the outputs are frozen so a commit cannot tear a digit mid-draw
  assign slot_update = !in_range || (in_range != in_range_reg) || (sel != sel_reg);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      in_range_reg <= 1'b0;
      sel_reg      <= '0;
      x_reg        <= X0;
      number_reg   <= 4'd0;
      en_reg       <= 1'b0;
    end else if (slot_update) begin
      in_range_reg <= in_range;
      sel_reg      <= sel;
      x_reg        <= sel_x;
      number_reg   <= digit_w[sel];
      en_reg       <= in_range & slot_en[sel];
    end
  end

  assign bus.x_out        = x_reg;
  assign bus.y_out        = Y0;
  assign bus.number_out   = number_reg;
  assign bus.digit_en_out = en_reg;
  assign bus.busy_out     = busy;
  assign bus.sat_out      = sat_reg;
endmodule

// File: tb/tb_score_digit_sequencer.sv
// Self-checking bench for score_digit_sequencer: table of scores, scoreboard of expected
// slot outputs over hcount sweeps, plus reset/ignored-pulse/mid-line-commit sequences.
module tb_score_digit_sequencer;
  localparam int SCORE_W = 14;
  localparam int CONV_CYCLES = SCORE_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_digit_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

  score_digit_sequencer #(.SCORE_W(SCORE_W)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus)
  );

  typedef struct {
    logic [13:0] score;
    logic [15:0] digits;   // BCD, slot 0 in the top nibble
    logic        sat;
    logic [3:0]  en_blank; // bit 3-k = slot k enabled with leading-zero blanking
  } vec_t;

  typedef struct {
    logic [10:0] h;
    logic [10:0] x;
    logic [3:0]  num;
    logic        en;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cur_digits = 16'h0000;
  logic [3:0]  cur_en = 4'b0000;

  function automatic logic [3:0] en_mask(input logic [3:0] blank);
`ifdef LEADING_ZERO_BLANK_EN
    return blank;
`else
    return (blank == 4'b0000) ? 4'b0000 : 4'b1111;
`endif
  endfunction

  function automatic exp_t model(input logic [10:0] h);
    exp_t e;
    int   k;
    e.h   = h;
    e.x   = 11'd16;
    e.num = cur_digits[15:12];
    e.en  = 1'b0;
    if (h >= 11'd16 && h < 11'd144) begin
      k     = (int'(h) - 16) / 32;
      e.x   = 11'(16 + 32 * k);
      e.num = cur_digits[(3-k)*4 +: 4];
      e.en  = cur_en[3-k];
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("x_out h=%0d", e.h), 32'(bus.x_out), 32'(e.x));
      chk($sformatf("number_out h=%0d", e.h), 32'(bus.number_out), 32'(e.num));
      chk($sformatf("digit_en_out h=%0d", e.h), 32'(bus.digit_en_out), 32'(e.en));
    end
  endtask

  // Outputs for hcount h are registered on the edge where hcount_in = h-1
  task automatic sweep(input int lo, input int hi);
    logic [10:0] d;
    d = 11'(lo - 1);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      pop_check();
      bus.hcount_in = d;
      sb.push_back(model(d + 11'd1));
      d = d + 11'd1;
    end
    @(negedge clk);
    pop_check();
  endtask

  task automatic convert(input logic [13:0] s, input bit dup_pulse, output int busy_cycles);
    @(negedge clk);
    bus.score_in     = s;
    bus.new_frame_in = 1'b1;
    @(negedge clk);
    bus.new_frame_in = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && bus.busy_out; i++) begin
      busy_cycles++;
      if (dup_pulse && i == 2) begin
        bus.score_in     = 14'd5678;
        bus.new_frame_in = 1'b1;
      end else begin
        bus.new_frame_in = 1'b0;
      end
      @(negedge clk);
    end
    bus.new_frame_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0, 4'b1111};
    vecs[1] = '{14'd20000 % 16384, 16'h3616, 1'b0, 4'b1111};
    vecs[2] = '{14'd5,     16'h0005, 1'b0, 4'b0001};
    vecs[3] = '{14'd42,    16'h0042, 1'b0, 4'b0011};
    vecs[4] = '{14'd0,     16'h0000, 1'b0, 4'b0001};
    vecs[5] = '{14'd9999,  16'h9999, 1'b0, 4'b1111};
    vecs[6] = '{14'd10000, 16'h9999, 1'b1, 4'b1111};
    vecs[7] = '{14'd16383, 16'h9999, 1'b1, 4'b1111};
    vecs[8] = '{14'd100,   16'h0100, 1'b0, 4'b0111};
    vecs[9] = '{14'd7001,  16'h7001, 1'b0, 4'b1111};

    bus.hcount_in    = 11'd0;
    bus.new_frame_in = 1'b0;
    bus.score_in     = '0;

    repeat (3) @(negedge clk);
    chk("reset busy_out", 32'(bus.busy_out), 0);
    chk("reset x_out", 32'(bus.x_out), 16);
    chk("reset y_out", 32'(bus.y_out), 16);
    chk("reset number_out", 32'(bus.number_out), 0);
    chk("reset digit_en_out", 32'(bus.digit_en_out), 0);
    chk("reset sat_out", 32'(bus.sat_out), 0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      bus.hcount_in = 11'd2047;
      convert(vecs[v].score, 1'b0, bc);
      chk($sformatf("busy cycles score=%0d", vecs[v].score), 32'(bc), 32'(CONV_CYCLES));
      chk($sformatf("sat_out score=%0d", vecs[v].score), 32'(bus.sat_out), 32'(vecs[v].sat));
      cur_digits = vecs[v].digits;
      cur_en     = en_mask(vecs[v].en_blank);
      sweep(0, 150);
      $display("case %0d: score=%0d digits=%h sat=%0d en=%b", v, vecs[v].score,
               vecs[v].digits, vecs[v].sat, cur_en);
    end

    // 20000 does not fit 14 bits; drive a true saturating value through the full width
    bus.hcount_in = 11'd2047;
    convert(14'd12000, 1'b0, bc);
    chk("busy cycles score=12000", 32'(bc), 32'(CONV_CYCLES));
    chk("sat_out score=12000", 32'(bus.sat_out), 1);
    cur_digits = 16'h9999;
    cur_en     = en_mask(4'b1111);
    sweep(0, 150);
    convert(14'd5, 1'b0, bc);
    chk("sat_out clears score=5", 32'(bus.sat_out), 0);
    cur_digits = 16'h0005;
    cur_en     = en_mask(4'b0001);
    sweep(10, 150);
    $display("sequence: saturate 12000 then 5");

    // Second pulse three cycles into a conversion is ignored
    convert(14'd1234, 1'b1, bc);
    chk("busy cycles with ignored pulse", 32'(bc), 32'(CONV_CYCLES));
    cur_digits = 16'h1234;
    cur_en     = en_mask(4'b1111);
    sweep(14, 146);
    $display("sequence: ignored second new_frame pulse");

    // Commit while parked inside slot 1 takes effect at the next slot boundary
    @(negedge clk);
    bus.hcount_in = 11'd59;
    repeat (2) @(negedge clk);
    convert(14'd5678, 1'b0, bc);
    repeat (3) @(negedge clk);
    chk("held slot number_out", 32'(bus.number_out), 2);
    chk("held slot x_out", 32'(bus.x_out), 48);
    bus.hcount_in = 11'd79;
    @(negedge clk);
    chk("next slot number_out", 32'(bus.number_out), 7);
    chk("next slot x_out", 32'(bus.x_out), 80);
    $display("sequence: mid-line commit 1234 -> 5678");

    // Asynchronous reset in the middle of SHIFT
    bus.hcount_in = 11'd2047;
    convert(14'd12000, 1'b0, bc);
    chk("sat before reset", 32'(bus.sat_out), 1);
    @(negedge clk);
    bus.score_in     = 14'd1234;
    bus.new_frame_in = 1'b1;
    @(negedge clk);
    bus.new_frame_in = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset busy_out", 32'(bus.busy_out), 0);
    chk("midreset x_out", 32'(bus.x_out), 16);
    chk("midreset number_out", 32'(bus.number_out), 0);
    chk("midreset digit_en_out", 32'(bus.digit_en_out), 0);
    chk("midreset sat_out", 32'(bus.sat_out), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post reset busy_out", 32'(bus.busy_out), 0);
    cur_digits = 16'h0000;
    cur_en     = en_mask(4'b0001);
    sweep(0, 150);
    $display("sequence: reset mid-SHIFT");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
